// File: rtl/ica_pkg.sv
// Shared widths, FSM state encoding and the signed saturation helper for the
// streaming unmixing block.
package ica_pkg;

    localparam int unsigned DW     = 16;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned WIDE_W = 64;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [ACC_W-1:0] val;
        logic                    ovf;
    } sat_t;

    // Clamp a wide signed value into ACC_W bits, flagging any clipping.
    function automatic sat_t sat_to_acc(input logic signed [WIDE_W-1:0] x);
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        sat_t                     r;
        hi    = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
        lo    = -hi - 64'sd1;
        r.val = x[ACC_W-1:0];
        r.ovf = 1'b0;
        if (x > hi) begin
            r.val = hi[ACC_W-1:0];
            r.ovf = 1'b1;
        end else if (x < lo) begin
            r.val = lo[ACC_W-1:0];
            r.ovf = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ica_unmix_stream_if.sv
// Sample stream, result stream and weight-programming port of the unmixing block.
interface ica_unmix_stream_if
    import ica_pkg::*;
#(
    parameter int unsigned N_CH = 3
);
    localparam int unsigned RW = $clog2(N_CH);

    logic                    in_valid;
    logic                    in_ready;
    logic [N_CH*DW-1:0]      x_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [N_CH*ACC_W-1:0]   u_out;
    logic [N_CH-1:0]         out_sat;
    logic                    out_last;
    logic                    w_wr_en;
    logic [RW-1:0]           w_wr_row;
    logic [RW-1:0]           w_wr_col;
    logic [DW-1:0]           w_wr_data;
    logic                    w_commit;
    logic                    w_pending;

    modport master (
        output in_valid, x_in, out_ready, w_wr_en, w_wr_row, w_wr_col, w_wr_data, w_commit,
        input  in_ready, out_valid, u_out, out_sat, out_last, w_pending
    );

    modport slave (
        input  in_valid, x_in, out_ready, w_wr_en, w_wr_row, w_wr_col, w_wr_data, w_commit,
        output in_ready, out_valid, u_out, out_sat, out_last, w_pending
    );

endinterface

// File: rtl/ica_row_dot.sv
// One unmixing row: full-precision dot product of a weight row with x,
// saturated to the output width.
module ica_row_dot
    import ica_pkg::*;
#(
    parameter int unsigned N_CH = 3
) (
    input  logic [N_CH*DW-1:0] i_w_row,
    input  logic [N_CH*DW-1:0] i_x,
    output logic [ACC_W-1:0]   o_u_c,
    output logic               o_sat_c
);
    localparam int unsigned SUM_W = 2 * DW + $clog2(N_CH) + 1;

    logic signed [SUM_W-1:0] w_sum;
    sat_t                    w_res;

    // Operands are widened before the multiply so the product is not truncated.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            w_sum = w_sum + SUM_W'($signed(i_w_row[k*DW +: DW])) * SUM_W'($signed(i_x[k*DW +: DW]));
        end
        w_res   = sat_to_acc(WIDE_W'(w_sum));
        o_u_c   = w_res.val;
        o_sat_c = w_res.ovf;
    end

endmodule

// File: rtl/ica_unmix_stream.sv
// Streaming u = W*x: one shared row engine, double-buffered weights with
// frame-aligned commit, frame tagging and saturating outputs.
module ica_unmix_stream
    import ica_pkg::*;
#(
    parameter int unsigned N_CH      = 3,
    parameter int unsigned FRAME_LEN = 64
) (
    input  logic               clk,
    input  logic               reset,
    ica_unmix_stream_if.slave  bus
);
    localparam int unsigned RW = $clog2(N_CH);
    localparam int unsigned FW = $clog2(FRAME_LEN);

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [RW-1:0]           r_row;
    logic [FW-1:0]           r_frame;
    logic                    r_pending;
    logic [N_CH*DW-1:0]      r_x;
    logic [N_CH*ACC_W-1:0]   r_u;
    logic [N_CH-1:0]         r_sat;
    logic                    r_last;
    logic signed [DW-1:0]    r_w_act [N_CH][N_CH];
    logic signed [DW-1:0]    r_w_sh  [N_CH][N_CH];

    logic                    w_accept;
    logic                    w_hs;
    logic                    w_last_row;
    logic                    w_frame_end;
    logic                    w_commit_now;
    logic                    w_copy;
    logic                    w_wr_ok;
    logic [N_CH*DW-1:0]      w_w_row;
    logic [ACC_W-1:0]        w_dot;
    logic                    w_dot_sat;

    assign w_accept     = bus.in_valid & r_in_ready;
    assign w_hs         = r_out_valid & bus.out_ready;
    assign w_last_row   = (r_row == RW'(N_CH - 1));
    assign w_frame_end  = (r_frame == FW'(FRAME_LEN - 1));
    assign w_commit_now = bus.w_commit & (r_state == S_IDLE) & (r_frame == '0);
    // Deferred commits land on the handshake that closes the frame.
    assign w_copy       = w_commit_now | (w_hs & w_frame_end & r_pending);
    assign w_wr_ok      = bus.w_wr_en & (32'(bus.w_wr_row) < N_CH) & (32'(bus.w_wr_col) < N_CH);

    always_comb begin
        w_w_row = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            w_w_row[k*DW +: DW] = r_w_act[r_row][k];
        end
    end

    ica_row_dot #(.N_CH(N_CH)) u_row_dot (
        .i_w_row (w_w_row),
        .i_x     (r_x),
        .o_u_c   (w_dot),
        .o_sat_c (w_dot_sat)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept)   w_next = S_COMPUTE;
            S_COMPUTE: if (w_last_row) w_next = S_OUTPUT;
            S_OUTPUT:  if (w_hs)       w_next = S_IDLE;
            default:                   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_row       <= '0;
            r_frame     <= '0;
            r_pending   <= 1'b0;
            r_x         <= '0;
            r_u         <= '0;
            r_sat       <= '0;
            r_last      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == S_IDLE);
            r_out_valid <= (w_next == S_OUTPUT);
            if (w_accept) begin
                r_x   <= bus.x_in;
                r_row <= '0;
            end
            if (r_state == S_COMPUTE) begin
                r_u[32'(r_row)*ACC_W +: ACC_W] <= w_dot;
                r_sat[r_row]                  <= w_dot_sat;
                r_row                         <= w_last_row ? '0 : r_row + RW'(1);
                if (w_last_row) r_last <= w_frame_end;
            end
            if (w_hs) r_frame <= w_frame_end ? '0 : r_frame + FW'(1);
            if (w_hs & w_frame_end & r_pending)  r_pending <= 1'b0;
            else if (bus.w_commit & ~w_commit_now) r_pending <= 1'b1;
        end
    end

    // Copy reads the shadow bank as it stood before any same-edge write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < int'(N_CH); r++) begin
                for (int c = 0; c < int'(N_CH); c++) begin
                    r_w_act[r][c] <= (r == c) ? DW'(1) : DW'(0);
                    r_w_sh[r][c]  <= (r == c) ? DW'(1) : DW'(0);
                end
            end
        end else begin
            if (w_copy)  r_w_act <= r_w_sh;
            if (w_wr_ok) r_w_sh[bus.w_wr_row][bus.w_wr_col] <= bus.w_wr_data;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.u_out     = r_u;
    assign bus.out_sat   = r_sat;
    assign bus.out_last  = r_last;
    assign bus.w_pending = r_pending;

endmodule

// File: tb/tb_ica_unmix_stream.sv
// Directed-plus-random bench for ica_unmix_stream against a matrix-level model.
module tb_ica_unmix_stream;
    import ica_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned FL = 64;
    localparam int unsigned RW = $clog2(N);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ica_unmix_stream_if #(.N_CH(N)) bus ();

    ica_unmix_stream #(.N_CH(N), .FRAME_LEN(FL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: matrices as plain ints, frame position and pending flag.
    int m_act [N][N];
    int m_sh  [N][N];
    int m_frame;
    bit m_pending;
    int xv    [N];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int r = 0; r < int'(N); r++)
            for (int c = 0; c < int'(N); c++) begin
                m_act[r][c] = (r == c) ? 1 : 0;
                m_sh[r][c]  = (r == c) ? 1 : 0;
            end
        m_frame   = 0;
        m_pending = 1'b0;
    endtask

    task automatic model_commit();
        if (m_frame == 0) m_act = m_sh;
        else              m_pending = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.x_in      = '0;
        bus.out_ready = 1'b0;
        bus.w_wr_en   = 1'b0;
        bus.w_wr_row  = '0;
        bus.w_wr_col  = '0;
        bus.w_wr_data = '0;
        bus.w_commit  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Shadow write, optionally on the same edge as a commit request.
    task automatic wr(input int r, input int c, input int v, input bit cm);
        @(negedge clk);
        bus.w_wr_en   = 1'b1;
        bus.w_wr_row  = RW'(r);
        bus.w_wr_col  = RW'(c);
        bus.w_wr_data = DW'(v);
        bus.w_commit  = cm;
        @(posedge clk);
        if (cm) model_commit();
        if (r < int'(N) && c < int'(N)) m_sh[r][c] = v;
        @(negedge clk);
        bus.w_wr_en  = 1'b0;
        bus.w_commit = 1'b0;
    endtask

    task automatic commit();
        @(negedge clk);
        bus.w_commit = 1'b1;
        @(posedge clk);
        model_commit();
        @(negedge clk);
        bus.w_commit = 1'b0;
    endtask

    // Push xv through the block, check latency/result, optionally stall output.
    task automatic run_sample(input int hold);
        logic [N*DW-1:0]    xp;
        logic [N*ACC_W-1:0] eu;
        logic [N-1:0]       es;
        logic               el;
        longint             s, hi, lo;
        int                 n;
        hi = (longint'(1) << (ACC_W - 1)) - 1;
        lo = -hi - 1;
        for (int k = 0; k < int'(N); k++) xp[k*DW +: DW] = DW'(xv[k]);
        for (int r = 0; r < int'(N); r++) begin
            s = 0;
            for (int k = 0; k < int'(N); k++) s += longint'(m_act[r][k]) * longint'(xv[k]);
            es[r] = (s > hi) || (s < lo);
            if (s > hi) s = hi;
            if (s < lo) s = lo;
            eu[r*ACC_W +: ACC_W] = ACC_W'(s);
        end
        el = (m_frame == int'(FL) - 1);

        @(negedge clk);
        chk("in_ready_idle", 128'(bus.in_ready), 128'(1));
        bus.in_valid  = 1'b1;
        bus.x_in      = xp;
        bus.out_ready = 1'b0;
        @(posedge clk);
        n = 0;
        @(negedge clk);
        if (hold == 0) bus.in_valid = 1'b0;
        else           bus.x_in = ~xp;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("latency", 128'(n), 128'(N));
        chk("u_out", 128'(bus.u_out), 128'(eu));
        chk("out_sat", 128'(bus.out_sat), 128'(es));
        chk("out_last", 128'(bus.out_last), 128'(el));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_u_stable", 128'(bus.u_out), 128'(eu));
            chk("bp_valid", 128'(bus.out_valid), 128'(1));
            chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        m_frame = (m_frame + 1) % int'(FL);
        if (m_frame == 0 && m_pending) begin
            m_act     = m_sh;
            m_pending = 1'b0;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("post_hs_valid", 128'(bus.out_valid), 128'(0));
        chk("post_hs_in_ready", 128'(bus.in_ready), 128'(1));
        chk("w_pending", 128'(bus.w_pending), 128'(m_pending));
    endtask

    task automatic rand_x(input bit full);
        for (int k = 0; k < int'(N); k++)
            xv[k] = full ? int'($urandom_range(0, 65535)) - 32768
                         : int'($urandom_range(0, 2000)) - 1000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        do_reset();

        // Reset state.
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_u_out", 128'(bus.u_out), 128'(0));
        chk("rst_out_sat", 128'(bus.out_sat), 128'(0));
        chk("rst_out_last", 128'(bus.out_last), 128'(0));
        chk("rst_pending", 128'(bus.w_pending), 128'(0));

        // Identity pass-through.
        xv = '{5, -7, 3};
        run_sample(0);

        // Programmed matrix, out-of-range writes ignored, commit at frame 0.
        do_reset();
        wr(0, 0, 1, 0); wr(0, 1, 2, 0);  wr(0, 2, 3, 0);
        wr(1, 0, 0, 0); wr(1, 1, -1, 0); wr(1, 2, 0, 0);
        wr(2, 0, 4, 0); wr(2, 1, 0, 0);  wr(2, 2, -2, 0);
        wr(3, 0, 55, 0); wr(0, 3, 55, 0);
        commit();
        chk("commit_idle_pending", 128'(bus.w_pending), 128'(0));
        xv = '{10, 20, -5};
        run_sample(0);
        chk("prog_u_const", 128'(bus.u_out), 128'({32'sd50, -32'sd20, 32'sd35}));

        // Positive and negative saturation.
        do_reset();
        for (int r = 0; r < int'(N); r++) for (int c = 0; c < int'(N); c++) wr(r, c, 32767, 0);
        commit();
        xv = '{32767, 32767, 32767};
        run_sample(0);
        do_reset();
        for (int r = 0; r < int'(N); r++) for (int c = 0; c < int'(N); c++) wr(r, c, -32768, 0);
        commit();
        run_sample(0);

        // Same-edge write and commit: active takes the pre-write shadow.
        do_reset();
        wr(0, 0, 9, 1);
        rand_x(0);
        run_sample(0);

        // Frame tagging, deferred commit and backpressure.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            rand_x(i[0]);
            run_sample(0);
        end
        for (int r = 0; r < int'(N); r++)
            for (int c = 0; c < int'(N); c++) wr(r, c, int'($urandom_range(0, 400)) - 200, 0);
        commit();
        chk("deferred_pending", 128'(bus.w_pending), 128'(1));
        for (int i = 10; i <= 64; i++) begin
            rand_x(i % 3 == 0);
            run_sample(i == 20 ? 10 : 0);
        end

        // Asynchronous reset while row 1 is being computed.
        xv = '{7, 8, 9};
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x_in     = {16'sd9, 16'sd8, 16'sd7};
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("midrst_in_ready", 128'(bus.in_ready), 128'(1));
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        xv = '{1, 2, 3};
        run_sample(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
